// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_pkg
// Brief    : Register map, CR/SR bit positions, FSM states and command type
//            shared by the I2C Wishbone command sequencer.
// Revision : 1.0
// ============================================================================
package i2c_seq_pkg;

    localparam logic [2:0] PRER_LO = 3'd0;
    localparam logic [2:0] PRER_HI = 3'd1;
    localparam logic [2:0] CTR     = 3'd2;
    localparam logic [2:0] TXR_RXR = 3'd3;
    localparam logic [2:0] CR_SR   = 3'd4;

    localparam int CR_STA   = 7;
    localparam int CR_STO   = 6;
    localparam int CR_RD    = 5;
    localparam int CR_WR    = 4;
    localparam int CR_ACK   = 3;
    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    localparam logic [7:0] CTR_EN_VAL   = 8'h80;
    localparam logic [7:0] CR_STOP_ONLY = 8'h40;

    typedef enum logic [3:0] {
        INIT_PRELO = 4'd0,
        INIT_PREHI = 4'd1,
        INIT_CTR   = 4'd2,
        IDLE       = 4'd3,
        W_TXR      = 4'd4,
        W_CR       = 4'd5,
        R_SR       = 4'd6,
        R_RXR      = 4'd7,
        W_STO      = 4'd8,
        RESP       = 4'd9
    } e_seq_state;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       nack;
        logic [7:0] data;
    } t_i2c_cmd;

    function automatic logic [7:0] cr_byte(input t_i2c_cmd c);
        logic [7:0] v;
        v         = 8'h00;
        v[CR_STA] = c.start;
        v[CR_STO] = c.stop;
        v[CR_RD]  = c.read;
        v[CR_WR]  = ~c.read;
        v[CR_ACK] = c.read & c.nack;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_wb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_wb_master_if
// Brief    : Single-access Wishbone master; owns cyc/stb handshake and the
//            idle gap between accesses.
// Revision : 1.0
// ============================================================================
module i2c_wb_master_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_go,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_adr,
    input  logic [DATA_WIDTH-1:0] i_wdat,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rdat,
    output logic [ADDR_WIDTH-1:0] o_wb_adr,
    output logic [DATA_WIDTH-1:0] o_wb_dat,
    input  logic [DATA_WIDTH-1:0] i_wb_dat,
    output logic                  o_wb_we,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    input  logic                  i_wb_ack
);

    logic                  cyc_q,  cyc_d;
    logic                  we_q,   we_d;
    logic [ADDR_WIDTH-1:0] adr_q,  adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
            done_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            we_q   <= we_d;
            adr_q  <= adr_d;
            wdat_q <= wdat_d;
            rdat_q <= rdat_d;
            done_q <= done_d;
        end
    end

    // The done cycle doubles as the mandatory idle gap: no new access starts then.
    always_comb begin
        cyc_d  = cyc_q;
        we_d   = we_q;
        adr_d  = adr_q;
        wdat_d = wdat_q;
        rdat_d = rdat_q;
        done_d = 1'b0;
        if (cyc_q) begin
            if (i_wb_ack) begin
                cyc_d  = 1'b0;
                done_d = 1'b1;
                rdat_d = i_wb_dat;
            end
        end else if (i_go && !done_q) begin
            cyc_d  = 1'b1;
            we_d   = i_we;
            adr_d  = i_adr;
            wdat_d = i_wdat;
        end
    end

    assign o_ready  = ~cyc_q & ~done_q;
    assign o_done   = done_q;
    assign o_rdat   = rdat_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = wdat_q;
    assign o_wb_we  = we_q;
    assign o_wb_cyc = cyc_q;
    assign o_wb_stb = cyc_q;

endmodule
`default_nettype wire

// File: rtl/i2c_wb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_wb_cmd_sequencer
// Brief    : Initialises the I2C master core and turns byte commands into
//            TXR/CR writes plus SR polling. Macro I2C_SEQ_TIMEOUT_EN adds a
//            bounded SR poll with STOP-on-timeout.
// Revision : 1.0
// ============================================================================
module i2c_wb_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 3,
    parameter int          DATA_WIDTH   = 8,
    parameter logic [15:0] PRESCALE     = 16'd199,
    parameter int          POLL_TIMEOUT = 20000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_start,
    input  logic                  req_stop,
    input  logic                  req_read,
    input  logic                  req_nack,
    input  logic [7:0]            req_data,
    output logic                  rsp_valid,
    output logic                  rsp_rxack,
    output logic                  rsp_al,
    output logic                  rsp_timeout,
    output logic [7:0]            rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i
);

    e_seq_state state_q, state_d;
    t_i2c_cmd   cmd_q, cmd_d;
    logic       init_done_q, init_done_d;
    logic       rxack_q, rxack_d;
    logic       al_q, al_d;
    logic [7:0] data_q, data_d;

    logic                  if_go, if_we, if_ready, if_done;
    logic [ADDR_WIDTH-1:0] if_adr;
    logic [7:0]            if_wdat;
    logic [DATA_WIDTH-1:0] if_rdat;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    i2c_wb_master_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wb_if (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .i_go     (if_go),
        .i_we     (if_we),
        .i_adr    (if_adr),
        .i_wdat   (DATA_WIDTH'(if_wdat)),
        .o_ready  (if_ready),
        .o_done   (if_done),
        .o_rdat   (if_rdat),
        .o_wb_adr (wb_adr_o),
        .o_wb_dat (wb_dat_o),
        .i_wb_dat (wb_dat_i),
        .o_wb_we  (wb_we_o),
        .o_wb_cyc (wb_cyc_o),
        .o_wb_stb (wb_stb_o),
        .i_wb_ack (wb_ack_i)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= INIT_PRELO;
            cmd_q       <= '0;
            init_done_q <= 1'b0;
            rxack_q     <= 1'b0;
            al_q        <= 1'b0;
            data_q      <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            poll_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
            rxack_q     <= rxack_d;
            al_q        <= al_d;
            data_q      <= data_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            poll_cnt_q  <= poll_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        init_done_d = init_done_q;
        rxack_d     = rxack_q;
        al_d        = al_q;
        data_d      = data_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            INIT_PRELO: if (if_done) state_d = INIT_PREHI;
            INIT_PREHI: if (if_done) state_d = INIT_CTR;
            INIT_CTR: begin
                if (if_done) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (req_valid && init_done_q) begin
                    cmd_d.start = req_start;
                    cmd_d.stop  = req_stop;
                    cmd_d.read  = req_read;
                    cmd_d.nack  = req_nack;
                    cmd_d.data  = req_data;
                    state_d     = req_read ? W_CR : W_TXR;
                end
            end
            W_TXR: if (if_done) state_d = W_CR;
            W_CR: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
                if (if_done) state_d = R_SR;
            end
            R_SR: begin
                if (if_done) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    poll_cnt_d = poll_cnt_q + 1'b1;
`endif
                    // Arbitration loss wins over TIP; the core has already released the bus.
                    if (if_rdat[SR_AL]) begin
                        al_d    = 1'b1;
                        rxack_d = ~cmd_q.read & if_rdat[SR_RXACK];
                        data_d  = 8'h00;
                        state_d = RESP;
                    end else if (if_rdat[SR_TIP]) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                        if (poll_cnt_d >= CNT_W'(POLL_TIMEOUT)) state_d = W_STO;
`endif
                    end else if (cmd_q.read) begin
                        state_d = R_RXR;
                    end else begin
                        al_d    = 1'b0;
                        rxack_d = if_rdat[SR_RXACK];
                        data_d  = 8'h00;
                        state_d = RESP;
                    end
                end
            end
            R_RXR: begin
                if (if_done) begin
                    al_d    = 1'b0;
                    rxack_d = 1'b0;
                    data_d  = if_rdat[7:0];
                    state_d = RESP;
                end
            end
            W_STO: begin
                if (if_done) begin
                    al_d    = 1'b0;
                    rxack_d = 1'b0;
                    data_d  = 8'h00;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = INIT_PRELO;
        endcase
`ifdef I2C_SEQ_TIMEOUT_EN
        if (state_d == RESP && state_q != RESP) timeout_d = (state_q == W_STO);
`endif
    end

    always_comb begin
        if_go   = 1'b0;
        if_we   = 1'b1;
        if_adr  = ADDR_WIDTH'(PRER_LO);
        if_wdat = 8'h00;
        case (state_q)
            INIT_PRELO: begin if_go = 1'b1; if_wdat = PRESCALE[7:0]; end
            INIT_PREHI: begin if_go = 1'b1; if_adr = ADDR_WIDTH'(PRER_HI); if_wdat = PRESCALE[15:8]; end
            INIT_CTR:   begin if_go = 1'b1; if_adr = ADDR_WIDTH'(CTR); if_wdat = CTR_EN_VAL; end
            W_TXR:      begin if_go = 1'b1; if_adr = ADDR_WIDTH'(TXR_RXR); if_wdat = cmd_q.data; end
            W_CR:       begin if_go = 1'b1; if_adr = ADDR_WIDTH'(CR_SR); if_wdat = cr_byte(cmd_q); end
            R_SR:       begin if_go = 1'b1; if_we = 1'b0; if_adr = ADDR_WIDTH'(CR_SR); end
            R_RXR:      begin if_go = 1'b1; if_we = 1'b0; if_adr = ADDR_WIDTH'(TXR_RXR); end
            W_STO:      begin if_go = 1'b1; if_adr = ADDR_WIDTH'(CR_SR); if_wdat = CR_STOP_ONLY; end
            default:    ;
        endcase
        if_go = if_go & if_ready;
    end

    assign req_ready = (state_q == IDLE) & init_done_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rxack = rxack_q;
    assign rsp_al    = al_q;
    assign rsp_data  = data_q;
    assign init_done = init_done_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_wb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_wb_cmd_sequencer
// Brief    : Scoreboard bench with a one-wait-state I2C core register model.
// Revision : 1.0
// ============================================================================
module tb_i2c_wb_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_start = 1'b0, req_stop = 1'b0;
    logic       req_read = 1'b0, req_nack = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, rsp_valid, rsp_rxack, rsp_al, rsp_timeout, init_done;
    logic [7:0] rsp_data;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_we_o, wb_cyc_o, wb_stb_o;
    logic       wb_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [11:0] acc_q[$];
    logic [10:0] rsp_q[$];

    int         tip_left = 0, al_at = 0, poll_num = 0;
    logic       sr_rxack = 1'b0;
    logic [7:0] rxr_val = 8'h00;
    logic       ws = 1'b0;

    always #5 clk = ~clk;

    i2c_wb_cmd_sequencer #(
        .ADDR_WIDTH   (3),
        .DATA_WIDTH   (8),
        .PRESCALE     (16'd199),
        .POLL_TIMEOUT (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_start   (req_start),
        .req_stop    (req_stop),
        .req_read    (req_read),
        .req_nack    (req_nack),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_rxack   (rsp_rxack),
        .rsp_al      (rsp_al),
        .rsp_timeout (rsp_timeout),
        .rsp_data    (rsp_data),
        .init_done   (init_done),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_ack_i    (wb_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] acc(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        return {we, adr, we ? dat : 8'h00};
    endfunction

    // Register-file model: one wait state, then ack; logs every completed access.
    initial forever begin
        @(posedge clk);
        #1;
        if (wb_ack_i) begin
            wb_ack_i = 1'b0;
            ws       = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (ws) begin
                wb_dat_i = 8'h00;
                if (!wb_we_o && wb_adr_o == 3'd4) begin
                    poll_num++;
                    wb_dat_i[7] = sr_rxack;
                    if (al_at != 0 && poll_num == al_at) wb_dat_i[5] = 1'b1;
                    if (tip_left > 0) begin
                        wb_dat_i[1] = 1'b1;
                        tip_left--;
                    end
                end else if (!wb_we_o && wb_adr_o == 3'd3) begin
                    wb_dat_i = rxr_val;
                end
                if (acc_q.size() == 0) check("acc_unexpected", acc(wb_we_o, wb_adr_o, wb_dat_o), 12'hFFF);
                else check("acc", acc(wb_we_o, wb_adr_o, wb_dat_o), acc_q.pop_front());
                wb_ack_i = 1'b1;
            end else begin
                ws = 1'b1;
            end
        end else begin
            ws = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rsp_valid) begin
            if (rsp_q.size() == 0) check("rsp_unexpected", {rsp_timeout, rsp_al, rsp_rxack, rsp_data}, 11'h7FF);
            else check("rsp", {rsp_timeout, rsp_al, rsp_rxack, rsp_data}, rsp_q.pop_front());
        end
    end

    task automatic push_init();
        acc_q.push_back(acc(1'b1, 3'd0, 8'hC7));
        acc_q.push_back(acc(1'b1, 3'd1, 8'h00));
        acc_q.push_back(acc(1'b1, 3'd2, 8'h80));
    endtask

    task automatic wait_init();
        for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
        check("init_done", init_done, 1'b1);
        check("init_acc_drain", acc_q.size(), 0);
        check("init_ready", req_ready, 1'b1);
    endtask

    task automatic issue(input logic s, input logic p, input logic r, input logic n, input logic [7:0] d);
        @(negedge clk);
        req_start = s; req_stop = p; req_read = r; req_nack = n; req_data = d;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_drop", req_ready, 1'b0);
    endtask

    // Sets up the core model, queues expected traffic/response and runs one command.
    task automatic run_cmd(input logic s, input logic p, input logic r, input logic n, input logic [7:0] d,
                           input int tips, input int al_poll, input logic rxack, input logic [7:0] rxr,
                           input logic timeout_case);
        logic [7:0] cr;
        int         polls;
        tip_left = tips; al_at = al_poll; poll_num = 0; sr_rxack = rxack; rxr_val = rxr;
        cr = {s, p, r, ~r, r & n, 3'b000};
        if (!r) acc_q.push_back(acc(1'b1, 3'd3, d));
        acc_q.push_back(acc(1'b1, 3'd4, cr));
        polls = timeout_case ? 8 : (al_poll != 0 ? al_poll : tips + 1);
        for (int i = 0; i < polls; i++) acc_q.push_back(acc(1'b0, 3'd4, 8'h00));
        if (timeout_case) begin
            acc_q.push_back(acc(1'b1, 3'd4, 8'h40));
            rsp_q.push_back({1'b1, 1'b0, 1'b0, 8'h00});
        end else if (al_poll != 0) begin
            rsp_q.push_back({1'b0, 1'b1, ~r & rxack, 8'h00});
        end else if (r) begin
            acc_q.push_back(acc(1'b0, 3'd3, 8'h00));
            rsp_q.push_back({1'b0, 1'b0, 1'b0, rxr});
        end else begin
            rsp_q.push_back({1'b0, 1'b0, rxack, 8'h00});
        end
        issue(s, p, r, n, d);
        for (int i = 0; i < 3000 && rsp_q.size() != 0; i++) @(negedge clk);
        check("rsp_drain", rsp_q.size(), 0);
        check("acc_drain", acc_q.size(), 0);
        @(negedge clk);
        check("ready_back", req_ready, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        push_init();
        rst = 1'b0;
        wait_init();

        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'hA2, 3, 0, 1'b0, 8'h00, 1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 0, 0, 1'b1, 8'h00, 1'b0);
        run_cmd(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1, 0, 1'b0, 8'h3C, 1'b0);
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'hA4, 5, 2, 1'b0, 8'h00, 1'b0);
`ifdef I2C_SEQ_TIMEOUT_EN
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1000, 0, 1'b0, 8'h00, 1'b1);
`endif

        // Reset during an SR poll must abort the bus cycle immediately.
        tip_left = 1000; al_at = 0; poll_num = 0;
        acc_q.push_back(acc(1'b1, 3'd3, 8'h77));
        acc_q.push_back(acc(1'b1, 3'd4, 8'h10));
        issue(1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        for (int i = 0; i < 200 && !(wb_cyc_o && !wb_we_o && wb_adr_o == 3'd4); i++) begin
            @(negedge clk);
            if (acc_q.size() == 0) acc_q.push_back(acc(1'b0, 3'd4, 8'h00));
        end
        check("sr_poll_seen", {wb_cyc_o, wb_we_o, wb_adr_o}, 5'b10100);
        rst = 1'b1;
        #1;
        check("arst_cyc", wb_cyc_o, 1'b0);
        check("arst_stb", wb_stb_o, 1'b0);
        check("arst_init_done", init_done, 1'b0);
        acc_q.delete();
        rsp_q.delete();
        tip_left = 0;
        repeat (3) @(negedge clk);
        push_init();
        rst = 1'b0;
        wait_init();
        run_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 0, 0, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_wb_cmd_sequencer.md
Name: i2c_wb_cmd_sequencer

Overview:
- Wishbone master that programs and sequences the byte-level I2C master core through its 8-bit, 3-bit-address register file.
- After reset it loads the prescaler and enables the core. It then turns single-byte command requests into TXR/CR writes, polls SR until the transfer completes, and returns the ACK, arbitration and read-data status.
- Sits between upper-level transaction logic (or the test harness) and the I2C master core's Wishbone slave port.

Parameters:
- ADDR_WIDTH, 3, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- PRESCALE, 16'd199, prescaler value: CLK_FREQ_MHZ*1e6/(5*SCL)-1. The default gives 100 kHz SCL at 100 MHz.
- POLL_TIMEOUT, 20000, maximum SR reads per command. Used only with the optional feature.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  sequencer accepts a command.
- req_start  in  1  generate START/repeated START before the byte.
- req_stop  in  1  generate STOP after the byte.
- req_read  in  1  1 = read byte, 0 = write byte.
- req_nack  in  1  on reads, master sends NACK.
- req_data  in  8  byte to transmit (slave address or data).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rxack  out  1  SR.RxACK captured (1 = slave NACKed).
- rsp_al  out  1  arbitration lost.
- rsp_timeout  out  1  poll timeout (only with the optional feature, else tied 0).
- rsp_data  out  8  RXR value on reads, 0 on writes.
- init_done  out  1  core configured.
- wb_adr_o  out  3  register address.
- wb_dat_o  out  8  write data.
- wb_dat_i  in  8  read data.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset: all outputs 0; state INIT_PRELO; internal registers cleared.
- Reset is asynchronous. Mid-operation reset aborts any Wishbone cycle immediately (cyc/stb go to 0) and re-runs the init sequence.
- Wishbone access rules:
  - One access at a time. cyc/stb/we/adr/dat are registered and held stable until wb_ack_i.
  - Capture wb_dat_i on the ack cycle.
  - cyc/stb go to 0 for at least one cycle between accesses.
  - No timeout on ack.
- Register map:
  - 0 = PRERlo; 1 = PRERhi; 2 = CTR (bit7 EN).
  - 3 = TXR on write, RXR on read.
  - 4 = CR on write (STA b7, STO b6, RD b5, WR b4, ACK b3); SR on read (RxACK b7, AL b5, TIP b1).
- Init sequence: INIT_PRELO writes PRESCALE[7:0] -> INIT_PREHI writes PRESCALE[15:8] -> INIT_CTR writes 8'h80 -> IDLE. init_done is set on entry to IDLE and stays high until reset.
- IDLE:
  - req_ready = 1 only in IDLE with init_done set.
  - A handshake (valid & ready) latches all req_* fields; req_ready drops the next cycle.
  - Write command goes to W_TXR; read command goes straight to W_CR.
- W_TXR: write latched req_data to address 3 -> W_CR.
- W_CR: write {start, stop, read, ~read, read&nack, 3'b000} to address 4 -> R_SR.
- R_SR: read address 4.
  - AL = 1: RESP with rsp_al = 1; sequencer does not issue STOP.
  - TIP = 1: issue another R_SR access.
  - TIP = 0: go to R_RXR if read, else RESP.
  - AL has priority over TIP.
- R_RXR: read address 3 into rsp_data -> RESP.
- RESP: rsp_valid high for exactly one cycle; rsp_* fields are valid in that cycle and held until the next response. Then IDLE.
  - rsp_rxack is the SR.RxACK value from the final SR read. On reads it is don't-care and is driven 0.
- Minimum latency:
  - Write command with TIP already clear on the first poll: 3 accesses.
  - Read command: 3 accesses (CR, SR, RXR).
  - Each access costs at least 2 cycles (request, ack) plus 1 idle cycle.

Optional Feature:
- Macro I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A poll counter clears on entry to W_CR and increments on each SR read.
  - On reaching POLL_TIMEOUT with TIP still 1, the sequencer writes CR = 8'h40 (STO), then enters RESP with rsp_timeout = 1.
- Undefined: the sequencer polls indefinitely; rsp_timeout is constant 0 and the counter logic is absent.

Decomposition:
- Package i2c_seq_pkg holds:
  - the register address localparams (PRER_LO, PRER_HI, CTR, TXR_RXR, CR_SR);
  - the CR/SR bit-index localparams;
  - the state enum e_seq_state;
  - the packed struct t_i2c_cmd (start, stop, read, nack, data).
- Sub-module i2c_wb_master_if: single-access Wishbone master with go/we/adr/wdat in and done/rdat out; it owns the cyc/stb handshake and the idle gap. The top-level FSM only sequences it.

Test Plan:
- Reset release, slave acks each access after 1 wait state -> writes adr 0 = C7, adr 1 = 00, adr 2 = 80, in that order; init_done rises; req_ready = 1.
- Write command start = 1, data = 8'hA2, TIP model high for 3 polls, RxACK = 0 -> TXR = A2, CR = 90, 4 SR reads; rsp_valid pulse with rsp_rxack = 0, rsp_al = 0.
- Write command stop = 1, data = 8'h55, RxACK = 1 -> CR = 50; rsp_rxack = 1.
- Read command nack = 1, stop = 1, RXR returns 8'h3C -> CR = 68; RXR read; rsp_data = 3C.
- SR returns AL = 1 on the 2nd poll -> no further accesses; rsp_al = 1; back to IDLE with req_ready = 1.
- TIP stuck high with I2C_SEQ_TIMEOUT_EN defined and POLL_TIMEOUT = 8 -> 8 SR reads, CR = 40, rsp_timeout = 1.
- Assert wb_rst_i during an SR poll -> cyc/stb drop at once and the init sequence repeats.
